// File: rtl/dphy_rx_pkg.sv
// dphy_rx_pkg: shared types and constants for the D-PHY lane receiver.
// FSM state encodings, default HS sync byte and LP line codes {dp,dn}.
package dphy_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    BRIDGE    = 3'd3,
    SYNC      = 3'd4,
    HS_DATA   = 3'd5,
    WAIT_STOP = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

endpackage

// File: rtl/dphy_lane_deser_if.sv
// dphy_lane_deser_if: lane pins in, deserialized byte stream out.
// master drives the lane (bus model side), slave is the receiver.
interface dphy_lane_deser_if;
  logic       en;
  logic       dp;
  logic       dn;
  logic [7:0] data;
  logic       data_valid;
  logic       sop;
  logic       hs_end;
  logic       err;
  logic [2:0] state;

  modport master (
    output en, dp, dn,
    input  data, data_valid, sop, hs_end, err, state
  );

  modport slave (
    input  en, dp, dn,
    output data, data_valid, sop, hs_end, err, state
  );
endinterface

// File: rtl/dphy_lp_filter.sv
// dphy_lp_filter: run-length filter on the registered {dp,dn} pair.
// ok is high while the current sample ends a run of >= LP_FILT equal ones.
module dphy_lp_filter
  import dphy_rx_pkg::*;
#(
  parameter int LP_FILT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sample,
  output logic [1:0] lp,
  output logic       ok
);

  logic [1:0] last_q;
  logic [3:0] cnt_q;
  logic [3:0] run;

  always_comb begin
    run = 4'd1;
    if (sample == last_q)
      run = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  assign ok = (run >= 4'(LP_FILT));
  assign lp = sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= LP00;
    end else begin
      cnt_q  <= run;
      last_q <= sample;
    end
  end

endmodule

// File: rtl/dphy_lane_deser.sv
// dphy_lane_deser: single-lane D-PHY HS receiver with LP sequencing.
// Option DPHY_DESER_SYNC_TOL_EN: accept sync at Hamming distance 1.
module dphy_lane_deser
  import dphy_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         LP_FILT      = 2,
  parameter int         SYNC_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic       dp_i,
  input  logic       dn_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       sop_o,
  output logic       hs_end_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  logic [1:0] pair_q;
  logic [1:0] lp;
  logic       lp_ok;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d, sr_shift;
  logic [9:0] scnt_q, scnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       first_q, first_d;
  logic [7:0] byte_q, byte_d;
  logic       bv_q, bv_d;
  logic       sop_q, sop_d;
  logic       end_q, end_d;
  logic       err_q, err_d;

  logic hs_bit, lp11, lp00, lp01, lp10;
  logic sync_eq, sync_near, sync_go, tmo;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pair_q <= LP00;
    else            pair_q <= {dp_i, dn_i};
  end

  dphy_lp_filter #(
    .LP_FILT (LP_FILT)
  ) u_filt (
    .clk    (clk_i),
    .rst_n  (reset_n_i),
    .sample (pair_q),
    .lp     (lp),
    .ok     (lp_ok)
  );

  assign hs_bit   = pair_q[1] ^ pair_q[0];
  assign sr_shift = {pair_q[1], sr_q[7:1]};
  assign lp11     = lp_ok && (lp == LP11);
  assign lp00     = lp_ok && (lp == LP00);
  assign lp01     = lp_ok && (lp == LP01);
  assign lp10     = lp_ok && (lp == LP10);
  assign sync_eq  = (sr_shift == SYNC_BYTE);

`ifdef DPHY_DESER_SYNC_TOL_EN
  assign sync_near = ($countones(sr_shift ^ SYNC_BYTE) == 1);
`else
  assign sync_near = 1'b0;
`endif

  // scnt_q holds bits already seen; only a full 8-bit window may match
  assign sync_go = hs_bit && (scnt_q >= 10'd7) && (sync_eq || sync_near);
  assign tmo     = ({1'b0, scnt_q} + 11'd1) >= 11'(SYNC_TIMEOUT);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    first_d = first_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    sop_d   = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lp11) state_d = STOP;
        end
        STOP: begin
          if (lp01) begin
            state_d = HS_RQST;
          end else if (lp_ok && !lp11) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        HS_RQST: begin
          if (lp00) begin
            state_d = BRIDGE;
          end else if (lp11) begin
            state_d = STOP;
          end else if (lp10) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        BRIDGE: begin
          if (hs_bit) begin
            sr_d    = sr_shift;
            scnt_d  = 10'd1;
            state_d = SYNC;
          end else if (lp11) begin
            state_d = STOP;
          end
        end
        SYNC: begin
          if (lp11) begin
            end_d   = 1'b1;
            state_d = STOP;
          end else begin
            scnt_d = scnt_q + 10'd1;
            if (hs_bit) sr_d = sr_shift;
            if (sync_go) begin
              bcnt_d  = 3'd0;
              first_d = 1'b1;
              err_d   = !sync_eq;
              state_d = HS_DATA;
            end else if (tmo) begin
              err_d   = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        HS_DATA: begin
          if (lp11) begin
            end_d   = 1'b1;
            state_d = STOP;
          end else if (lp00) begin
            err_d   = 1'b1;
            state_d = WAIT_STOP;
          end else if (hs_bit) begin
            sr_d   = sr_shift;
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              byte_d  = sr_shift;
              bv_d    = 1'b1;
              sop_d   = first_q;
              first_d = 1'b0;
            end
          end
        end
        WAIT_STOP: begin
          if (lp11) state_d = STOP;
        end
        default: state_d = IDLE;
      endcase
    end
    if (err_d) begin
      bv_d  = 1'b0;
      sop_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      first_q <= 1'b0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      sop_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      first_q <= first_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      sop_q   <= sop_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bv_q;
  assign sop_o        = sop_q;
  assign hs_end_o     = end_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dphy_lane_deser.sv
// tb_dphy_lane_deser: directed + random bursts vs a bit-stream model.
// Model searches the HS bit list for the sync window, then slices bytes.
module tb_dphy_lane_deser;

  localparam logic [7:0] SB  = 8'hB8;
  localparam int         TMO = 64;

  typedef bit         bq_t[$];
  typedef logic [7:0] yq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dphy_lane_deser_if lane ();

  dphy_lane_deser dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .enable_i     (lane.en),
    .dp_i         (lane.dp),
    .dn_i         (lane.dn),
    .byte_o       (lane.data),
    .byte_valid_o (lane.data_valid),
    .sop_o        (lane.sop),
    .hs_end_o     (lane.hs_end),
    .err_o        (lane.err),
    .state_o      (lane.state)
  );

  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_end  = 0;
  int  n_err  = 0;
  int  n_both = 0;
  int  n_orph = 0;
  yq_t got_b;
  bit  got_s[$];
  bq_t stim;

  always @(negedge clk) begin
    if (lane.data_valid) begin
      got_b.push_back(lane.data);
      got_s.push_back(lane.sop);
    end
    if (lane.hs_end) n_end++;
    if (lane.err) n_err++;
    if (lane.err && lane.data_valid) n_both++;
    if (lane.sop && !lane.data_valid) n_orph++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sync = first 8-bit window (bit i-7 is LSB) matching, within TMO bits
  function automatic void model(input bq_t bits, output yq_t ys,
                                output int ne, output int nd);
    int found;
    bit tol;
    logic [7:0] w;
    int nb;
    found = -1;
    tol   = 1'b0;
    ys.delete();
    for (int i = 7; i < bits.size() && i < TMO && found < 0; i++) begin
      for (int j = 0; j < 8; j++) w[j] = bits[i-7+j];
      if (w == SB) found = i;
`ifdef DPHY_DESER_SYNC_TOL_EN
      else if ($countones(w ^ SB) == 1) begin
        found = i;
        tol   = 1'b1;
      end
`endif
    end
    if (found < 0) begin
      ne = (bits.size() >= TMO) ? 1 : 0;
      nd = (bits.size() >= TMO) ? 0 : 1;
    end else begin
      ne = tol ? 1 : 0;
      nd = 1;
      nb = (bits.size() - found - 1) / 8;
      for (int k = 0; k < nb; k++) begin
        for (int j = 0; j < 8; j++) w[j] = bits[found+1+8*k+j];
        ys.push_back(w);
      end
    end
  endfunction

  task automatic put(input bit p, input bit n);
    lane.dp = p;
    lane.dn = n;
    @(negedge clk);
  endtask

  task automatic put_n(input bit p, input bit n, input int k);
    repeat (k) put(p, n);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) stim.push_back(b[j]);
  endtask

  task automatic lead_in();
    put_n(1'b1, 1'b1, 3);
    put_n(1'b0, 1'b1, 3);
    put_n(1'b0, 1'b0, 3);
  endtask

  task automatic check_burst(input string tag, input int b0,
                             input int e0, input int r0);
    yq_t ey;
    int  xe, xd;
    model(stim, ey, xe, xd);
    check($sformatf("%s nbytes", tag), got_b.size() - b0, ey.size());
    foreach (ey[k]) begin
      if (b0 + k < got_b.size()) begin
        check($sformatf("%s byte%0d", tag, k), got_b[b0+k], ey[k]);
        check($sformatf("%s sop%0d", tag, k), got_s[b0+k], k == 0);
      end
    end
    check($sformatf("%s err", tag), n_err - r0, xe);
    check($sformatf("%s hs_end", tag), n_end - e0, xd);
    check($sformatf("%s state", tag), lane.state, 3'd1);
  endtask

  task automatic run_burst(input string tag);
    int b0, e0, r0;
    b0 = got_b.size();
    e0 = n_end;
    r0 = n_err;
    lead_in();
    foreach (stim[i]) put(stim[i], !stim[i]);
    put_n(1'b1, 1'b1, 6);
    check_burst(tag, b0, e0, r0);
  endtask

  initial begin
    int b0, e0, r0;
    int sel, nb, nt;
    logic [7:0] sb;
    lane.en = 1'b1;
    lane.dp = 1'b1;
    lane.dn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst state", lane.state, 3'd0);
    check("rst byte", lane.data, 8'h00);
    check("rst valid", lane.data_valid, 1'b0);
    check("rst sop", lane.sop, 1'b0);
    check("rst hs_end", lane.hs_end, 1'b0);
    check("rst err", lane.err, 1'b0);
    rst_n = 1'b1;

    stim.delete();
    add_byte(SB);
    add_byte(8'h2A);
    add_byte(8'h00);
    add_byte(8'hFF);
    add_byte(8'h5C);
    b0 = got_b.size();
    run_burst("nominal");
    check("nominal first", got_b[b0], 8'h2A);

    put(1'b0, 1'b1);
    put_n(1'b1, 1'b1, 3);
    check("glitch stays stop", lane.state, 3'd1);
    put_n(1'b0, 1'b1, 3);
    check("lp01 hs_rqst", lane.state, 3'd2);

    b0 = got_b.size();
    e0 = n_end;
    r0 = n_err;
    put_n(1'b0, 1'b0, 3);
    check("lp00 bridge", lane.state, 3'd3);
    for (int i = 0; i < 64; i++) put(i[0], !i[0]);
    put_n(1'b0, 1'b0, 2);
    check("tmo state", lane.state, 3'd6);
    check("tmo err", n_err - r0, 1);
    check("tmo bytes", got_b.size() - b0, 0);
    put_n(1'b1, 1'b1, 3);
    check("tmo stop", lane.state, 3'd1);
    check("tmo hs_end", n_end - e0, 0);

    stim.delete();
    add_byte(SB);
    add_byte(8'h12);
    stim.push_back(1'b1);
    stim.push_back(1'b0);
    stim.push_back(1'b1);
    run_burst("trail");

    stim.delete();
    add_byte(SB);
    add_byte(8'hA5);
    add_byte(8'h5A);
    b0 = got_b.size();
    e0 = n_end;
    lead_in();
    for (int i = 0; i < 12; i++) put(stim[i], !stim[i]);
    check("pre-rst hs_data", lane.state, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async rst state", lane.state, 3'd0);
    check("async rst byte", lane.data, 8'h00);
    check("async rst valid", lane.data_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 12; i < 24; i++) put(stim[i], !stim[i]);
    put_n(1'b1, 1'b1, 6);
    check("post-rst bytes", got_b.size() - b0, 0);
    check("post-rst hs_end", n_end - e0, 0);
    check("post-rst stop", lane.state, 3'd1);

    stim.delete();
    add_byte(SB);
    add_byte(8'hC3);
    b0 = got_b.size();
    e0 = n_end;
    r0 = n_err;
    lead_in();
    for (int i = 0; i < 12; i++) put(stim[i], !stim[i]);
    lane.en = 1'b0;
    put_n(1'b1, 1'b1, 2);
    check("disable idle", lane.state, 3'd0);
    lane.en = 1'b1;
    put_n(1'b1, 1'b1, 3);
    check("enable stop", lane.state, 3'd1);
    check("disable bytes", got_b.size() - b0, 0);
    check("disable err", n_err - r0, 0);
    check("disable hs_end", n_end - e0, 0);

    stim.delete();
    add_byte(8'hB9);
    repeat (7) add_byte(8'h55);
    r0 = n_err;
    run_burst("sync tol");
    check("sync tol err", n_err - r0, 1);

    for (int r = 0; r < 8; r++) begin
      stim.delete();
      sel = $urandom_range(0, 3);
      if (sel < 2) sb = SB;
      else if (sel == 2) sb = SB ^ (8'h01 << $urandom_range(0, 7));
      else sb = 8'($urandom);
      add_byte(sb);
      nb = $urandom_range(0, 4);
      repeat (nb) add_byte(8'($urandom));
      nt = $urandom_range(0, 7);
      repeat (nt) stim.push_back(1'($urandom_range(0, 1)));
      run_burst($sformatf("rand%0d", r));
    end

    check("err with valid", n_both, 0);
    check("sop without valid", n_orph, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
